hnf_loc_access_ctl: RTL and testbench

- Request front-end for the HN-F tag (LOC) SRAM path. Sits directly upstream of the memory-control stage and drives its cpl_loc_* request inputs.
- Queues tag read/write requests from the HN-F pipeline in a small FIFO. Holds them until the memory-control stage reports tag-array initialisation complete (notify bit 1), then issues at most one request per cycle.
- Returns tag read data, with the requester's tag, after a fixed SRAM read latency.

---
 rtl/hnf_loc_access_ctl_if.sv | 28 ++
 rtl/hnf_loc_access_ctl.sv | 153 +++++++++++++++
 tb/tb_hnf_loc_access_ctl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hnf_loc_access_ctl_if.sv
// Request/response bundle between the HN-F pipeline and the tag-SRAM request front-end.
interface hnf_loc_access_ctl_if #(
  parameter int IDX_W   = 9,
  parameter int WAY_NUM = 16,
  parameter int CLINE_W = 48,
  parameter int ID_W    = 6
);
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_wr;
  logic [ID_W-1:0]            req_id;
  logic [IDX_W-1:0]           req_index;
  logic [WAY_NUM-1:0]         req_wr_ways;
  logic [CLINE_W-1:0]         req_wr_cline;
  logic                       rsp_valid;
  logic [ID_W-1:0]            rsp_id;
  logic [WAY_NUM*CLINE_W-1:0] rsp_clines;

  modport slave (
    input  req_valid, req_wr, req_id, req_index, req_wr_ways, req_wr_cline,
    output req_ready, rsp_valid, rsp_id, rsp_clines
  );

  modport master (
    output req_valid, req_wr, req_id, req_index, req_wr_ways, req_wr_cline,
    input  req_ready, rsp_valid, rsp_id, rsp_clines
  );
endinterface

// File: rtl/hnf_loc_access_ctl.sv
// Tag-SRAM request front-end: DEPTH-entry FIFO held until tag init is done, then one issue per cycle straight off the head.
// Read data returns RD_LAT+1 cycles after issue; req_ready drops only when the FIFO is full; responses have no backpressure.
module hnf_loc_access_ctl #(
  parameter int IDX_W   = 9,
  parameter int WAY_NUM = 16,
  parameter int CLINE_W = 48,
  parameter int ID_W    = 6,
  parameter int DEPTH   = 4,
  parameter int RD_LAT  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 notify_reg,
  hnf_loc_access_ctl_if.slave        req_if,
  output logic [IDX_W-1:0]           cpl_loc_index_q,
  output logic                       cpl_loc_rd_en_q,
  output logic [WAY_NUM-1:0]         cpl_loc_wr_ways_q,
  output logic [CLINE_W-1:0]         cpl_loc_wr_cline_q,
  input  logic [WAY_NUM*CLINE_W-1:0] loc_rd_clines_q,
  output logic                       busy
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LINES_W = WAY_NUM * CLINE_W;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic               wr;
    logic [ID_W-1:0]    id;
    logic [IDX_W-1:0]   index;
    logic [WAY_NUM-1:0] wr_ways;
    logic [CLINE_W-1:0] wr_cline;
  } req_ent_t;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e               state_q, state_d;
  req_ent_t             fifo_q [DEPTH];
  req_ent_t             fifo_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       cnt_q, cnt_d;
  logic [RD_LAT-1:0]    pipe_vld_q, pipe_vld_d;
  logic [ID_W-1:0]      pipe_id_q [RD_LAT];
  logic [ID_W-1:0]      pipe_id_d [RD_LAT];
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [LINES_W-1:0]   rsp_clines_q, rsp_clines_d;
  req_ent_t             head;
  logic                 push, pop;
  logic                 unused_notify;

  // Only the tag-array init flag matters here.
  assign unused_notify = ^{notify_reg[2], notify_reg[0]};

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && notify_reg[1]) begin
      state_d = S_RUN;
    end
  end

  assign req_if.req_ready = (cnt_q != FULL_CNT);
  assign push = req_if.req_valid && req_if.req_ready;
  assign pop  = (state_q == S_RUN) && (cnt_q != '0);
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {req_if.req_wr, req_if.req_id, req_if.req_index,
                          req_if.req_wr_ways, req_if.req_wr_cline};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Issue is combinational off the head so a popped entry reaches the SRAM in its pop cycle.
  always_comb begin
    cpl_loc_index_q    = '0;
    cpl_loc_rd_en_q    = 1'b0;
    cpl_loc_wr_ways_q  = '0;
    cpl_loc_wr_cline_q = '0;
    if (pop) begin
      cpl_loc_index_q = head.index;
      if (head.wr) begin
        cpl_loc_wr_ways_q  = head.wr_ways;
        cpl_loc_wr_cline_q = head.wr_cline;
      end else begin
        cpl_loc_rd_en_q = 1'b1;
      end
    end
  end

  always_comb begin
    pipe_vld_d    = '0;
    pipe_id_d     = '{default: '0};
    pipe_vld_d[0] = cpl_loc_rd_en_q;
    pipe_id_d[0]  = cpl_loc_rd_en_q ? head.id : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
    rsp_valid_d  = pipe_vld_q[RD_LAT-1];
    rsp_id_d     = pipe_vld_q[RD_LAT-1] ? pipe_id_q[RD_LAT-1] : rsp_id_q;
    rsp_clines_d = pipe_vld_q[RD_LAT-1] ? loc_rd_clines_q : rsp_clines_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      pipe_vld_q   <= '0;
      pipe_id_q    <= '{default: '0};
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_clines_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_id_q    <= pipe_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_clines_q <= rsp_clines_d;
    end
  end

  // Entry storage needs no reset: the pointers alone define occupancy.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign req_if.rsp_valid  = rsp_valid_q;
  assign req_if.rsp_id     = rsp_id_q;
  assign req_if.rsp_clines = rsp_clines_q;
  assign busy = (cnt_q != '0) || (|pipe_vld_q);
endmodule

// File: tb/tb_hnf_loc_access_ctl.sv
// Bench for hnf_loc_access_ctl: vector table for the init phase, hand sequences for corner cases,
// and randomized traffic scored against a request-order memory model.
module tb_hnf_loc_access_ctl;
  localparam int IDX_W   = 9;
  localparam int WAY_NUM = 16;
  localparam int CLINE_W = 48;
  localparam int ID_W    = 6;
  localparam int DEPTH   = 4;
  localparam int RD_LAT  = 2;
  localparam int LW      = WAY_NUM * CLINE_W;
  typedef logic [LW-1:0] lines_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [2:0]         notify_reg = 3'b000;
  logic [IDX_W-1:0]   cpl_loc_index_q;
  logic               cpl_loc_rd_en_q;
  logic [WAY_NUM-1:0] cpl_loc_wr_ways_q;
  logic [CLINE_W-1:0] cpl_loc_wr_cline_q;
  lines_t             loc_rd_clines_q = '0;
  logic               busy;

  hnf_loc_access_ctl_if #(.IDX_W(IDX_W), .WAY_NUM(WAY_NUM), .CLINE_W(CLINE_W), .ID_W(ID_W)) rif ();

  hnf_loc_access_ctl #(
    .IDX_W(IDX_W), .WAY_NUM(WAY_NUM), .CLINE_W(CLINE_W), .ID_W(ID_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .notify_reg         (notify_reg),
    .req_if             (rif.slave),
    .cpl_loc_index_q    (cpl_loc_index_q),
    .cpl_loc_rd_en_q    (cpl_loc_rd_en_q),
    .cpl_loc_wr_ways_q  (cpl_loc_wr_ways_q),
    .cpl_loc_wr_cline_q (cpl_loc_wr_cline_q),
    .loc_rd_clines_q    (loc_rd_clines_q),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input lines_t act, input lines_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic lines_t init_line(input int idx);
    lines_t l;
    for (int w = 0; w < WAY_NUM; w++) l[w*CLINE_W +: CLINE_W] = CLINE_W'(idx * 1000 + w * 17 + 5);
    return l;
  endfunction

  // SRAM model: applies what the DUT issues; read data appears RD_LAT cycles after the read.
  lines_t sram [int];
  lines_t rdp [RD_LAT+1];
  always @(negedge clk) begin
    lines_t ln;
    for (int k = RD_LAT; k > 0; k--) rdp[k] = rdp[k-1];
    if (cpl_loc_rd_en_q)
      rdp[0] = sram.exists(int'(cpl_loc_index_q)) ? sram[int'(cpl_loc_index_q)] : init_line(int'(cpl_loc_index_q));
    else
      rdp[0] = {24{$urandom()}};
    if (cpl_loc_wr_ways_q != '0) begin
      ln = sram.exists(int'(cpl_loc_index_q)) ? sram[int'(cpl_loc_index_q)] : init_line(int'(cpl_loc_index_q));
      for (int w = 0; w < WAY_NUM; w++)
        if (cpl_loc_wr_ways_q[w]) ln[w*CLINE_W +: CLINE_W] = cpl_loc_wr_cline_q;
      sram[int'(cpl_loc_index_q)] = ln;
    end
    loc_rd_clines_q = rdp[RD_LAT];
  end

  // Reference: accepted requests in order; reads see every earlier-accepted write.
  typedef struct {
    logic               wr;
    logic [ID_W-1:0]    id;
    logic [IDX_W-1:0]   idx;
    logic [WAY_NUM-1:0] ways;
    logic [CLINE_W-1:0] cline;
  } req_t;
  typedef struct {
    logic [ID_W-1:0] id;
    lines_t          data;
  } rsp_t;

  lines_t ref_mem [int];
  req_t   iss_q [$];
  rsp_t   rsp_q [$];
  int     lat_q [$];
  int     cyc = 0;
  bit     model_run = 0;

  always @(negedge clk) begin
    bit     issued, exp_issue;
    req_t   h, n;
    rsp_t   r;
    lines_t ln;
    cyc++;
    if (!rst_n) begin
      iss_q.delete();
      rsp_q.delete();
      lat_q.delete();
      model_run = 0;
    end else begin
      issued    = cpl_loc_rd_en_q || (cpl_loc_wr_ways_q != '0);
      exp_issue = model_run && (iss_q.size() > 0);
      check("issue_when", lines_t'(issued), lines_t'(exp_issue));
      if (issued && exp_issue) begin
        h = iss_q.pop_front();
        check("issue_idx", lines_t'(cpl_loc_index_q), lines_t'(h.idx));
        check("issue_rd_en", lines_t'(cpl_loc_rd_en_q), lines_t'(!h.wr));
        check("issue_ways", lines_t'(cpl_loc_wr_ways_q), h.wr ? lines_t'(h.ways) : '0);
        check("issue_cline", lines_t'(cpl_loc_wr_cline_q), h.wr ? lines_t'(h.cline) : '0);
        if (!h.wr) lat_q.push_back(cyc);
      end else if (!issued) begin
        check("idle_bus", lines_t'({cpl_loc_index_q, cpl_loc_wr_cline_q}), '0);
      end
      if (rif.rsp_valid) begin
        check("rsp_expected", lines_t'(rsp_q.size() != 0), lines_t'(1));
        if (rsp_q.size() != 0 && lat_q.size() != 0) begin
          r = rsp_q.pop_front();
          check("rsp_id", lines_t'(rif.rsp_id), lines_t'(r.id));
          check("rsp_data", rif.rsp_clines, r.data);
          check("rsp_latency", lines_t'(cyc - lat_q.pop_front()), lines_t'(RD_LAT + 1));
        end
      end
      if (rif.req_valid && rif.req_ready) begin
        n = '{rif.req_wr, rif.req_id, rif.req_index, rif.req_wr_ways, rif.req_wr_cline};
        iss_q.push_back(n);
        ln = ref_mem.exists(int'(n.idx)) ? ref_mem[int'(n.idx)] : init_line(int'(n.idx));
        if (n.wr) begin
          for (int w = 0; w < WAY_NUM; w++) if (n.ways[w]) ln[w*CLINE_W +: CLINE_W] = n.cline;
          ref_mem[int'(n.idx)] = ln;
        end else begin
          rsp_q.push_back('{n.id, ln});
        end
      end
      if (notify_reg[1]) model_run = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input int id, input int idx,
                       input logic [WAY_NUM-1:0] ways, input logic [CLINE_W-1:0] cline);
    rif.req_valid    = v;
    rif.req_wr       = wr;
    rif.req_id       = ID_W'(id);
    rif.req_index    = IDX_W'(idx);
    rif.req_wr_ways  = ways;
    rif.req_wr_cline = cline;
  endtask

  typedef struct {
    logic v;
    int   id;
    int   idx;
    logic exp_ready;
    logic exp_busy;
    logic exp_rd_en;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [6];
    int   sent, it, k;
    bit   acc, seen;
    vt[0] = '{1'b1, 1, 'h010, 1'b1, 1'b1, 1'b0};
    vt[1] = '{1'b1, 2, 'h021, 1'b1, 1'b1, 1'b0};
    vt[2] = '{1'b1, 3, 'h032, 1'b1, 1'b1, 1'b0};
    vt[3] = '{1'b1, 4, 'h043, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b1, 5, 'h054, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b0, 0, 'h000, 1'b0, 1'b1, 1'b0};

    drive(1'b0, 1'b0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", lines_t'(rif.rsp_valid), '0);
    check("rst_busy", lines_t'(busy), '0);
    check("rst_rd_en", lines_t'(cpl_loc_rd_en_q), '0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", lines_t'(rif.req_ready), lines_t'(1));

    // Init phase: four reads fill the FIFO, the fifth is refused, nothing issues.
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].v, 1'b0, vt[i].id, vt[i].idx, '0, '0);
      tick();
      check($sformatf("vec%0d_ready", i), lines_t'(rif.req_ready), lines_t'(vt[i].exp_ready));
      check($sformatf("vec%0d_busy", i), lines_t'(busy), lines_t'(vt[i].exp_busy));
      check($sformatf("vec%0d_rd_en", i), lines_t'(cpl_loc_rd_en_q), lines_t'(vt[i].exp_rd_en));
    end

    // Release: four back-to-back issues, then four back-to-back responses.
    notify_reg = 3'b010;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("drain%0d_rd_en", i), lines_t'(cpl_loc_rd_en_q), lines_t'(i < 4));
      if (i < 4) check($sformatf("drain%0d_idx", i), lines_t'(cpl_loc_index_q), lines_t'(vt[i].idx));
      check($sformatf("drain%0d_rsp_v", i), lines_t'(rif.rsp_valid), lines_t'(i >= 3 && i < 7));
      if (i >= 3 && i < 7) check($sformatf("drain%0d_rsp_id", i), lines_t'(rif.rsp_id), lines_t'(i - 2));
    end

    // Write then read of the same index.
    drive(1'b1, 1'b1, 0, 'h1A, 16'h0004, 48'hABCD);
    tick();
    check("wr_issue_ways", lines_t'(cpl_loc_wr_ways_q), lines_t'(16'h0004));
    check("wr_issue_idx", lines_t'(cpl_loc_index_q), lines_t'(9'h01A));
    check("wr_issue_rd_en", lines_t'(cpl_loc_rd_en_q), '0);
    drive(1'b1, 1'b0, 7, 'h1A, '0, '0);
    tick();
    drive(1'b0, 1'b0, 0, 0, '0, '0);
    check("rd_issue_rd_en", lines_t'(cpl_loc_rd_en_q), lines_t'(1));
    check("rd_issue_ways", lines_t'(cpl_loc_wr_ways_q), '0);
    for (int j = 1; j <= 4; j++) begin
      tick();
      check($sformatf("raw%0d_rsp_v", j), lines_t'(rif.rsp_valid), lines_t'(j == 3));
      if (j >= 3) check($sformatf("raw%0d_way2", j), lines_t'(rif.rsp_clines[2*CLINE_W +: CLINE_W]), lines_t'(48'hABCD));
      if (j == 3) check("raw_rsp_id", lines_t'(rif.rsp_id), lines_t'(7));
    end

    // Reset with reads in flight and one queued: nothing may come back.
    drive(1'b1, 1'b0, 'h11, 'h101, '0, '0);
    tick();
    drive(1'b1, 1'b0, 'h12, 'h102, '0, '0);
    tick();
    drive(1'b1, 1'b0, 'h13, 'h103, '0, '0);
    tick();
    drive(1'b0, 1'b0, 0, 0, '0, '0);
    rst_n = 1'b0;
    notify_reg = 3'b000;
    #1;
    check("arst_busy", lines_t'(busy), '0);
    check("arst_rsp_valid", lines_t'(rif.rsp_valid), '0);
    check("arst_rd_en", lines_t'(cpl_loc_rd_en_q), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 'h22, 'h0AA, '0, '0);
    for (int j = 0; j < 6; j++) begin
      tick();
      drive(1'b0, 1'b0, 0, 0, '0, '0);
      check($sformatf("post_rst%0d_rsp_v", j), lines_t'(rif.rsp_valid), '0);
      check($sformatf("post_rst%0d_rd_en", j), lines_t'(cpl_loc_rd_en_q), '0);
    end
    check("post_rst_busy", lines_t'(busy), lines_t'(1));
    notify_reg = 3'b010;
    tick();
    check("rerun_rd_en", lines_t'(cpl_loc_rd_en_q), lines_t'(1));
    check("rerun_idx", lines_t'(cpl_loc_index_q), lines_t'(9'h0AA));
    seen = 0;
    k = 0;
    while (!seen && k < 8) begin
      tick();
      k++;
      if (rif.rsp_valid) begin
        seen = 1;
        check("rerun_rsp_id", lines_t'(rif.rsp_id), lines_t'(6'h22));
      end
    end
    if (!seen) fail_now("rerun_rsp_wait");

    // Random traffic from a fresh reset: fill in init, then stream with the FIFO pinned near full.
    rst_n = 1'b0;
    notify_reg = 3'b000;
    tick();
    rst_n = 1'b1;
    sent = 0;
    it = 0;
    while (sent < 100 && it < 3000) begin
      if (!rif.req_valid && (it < 12 || $urandom_range(7) != 0))
        drive(1'b1, 1'($urandom_range(1)), int'($urandom_range(63)), int'($urandom_range(7)),
              16'($urandom_range(65535, 1)), CLINE_W'({$urandom(), $urandom()}));
      @(negedge clk);
      acc = rif.req_valid && rif.req_ready;
      tick();
      it++;
      if (acc) begin
        sent++;
        rif.req_valid = 1'b0;
      end
      if (it == 10) begin
        check("fill_ready", lines_t'(rif.req_ready), '0);
        check("fill_count", lines_t'(sent), lines_t'(DEPTH));
        check("fill_no_issue", lines_t'(cpl_loc_rd_en_q || (cpl_loc_wr_ways_q != '0)), '0);
      end
      if (it == 12) notify_reg = 3'b010;
    end
    rif.req_valid = 1'b0;
    if (sent < 100) fail_now("rand_send");
    k = 0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    if (busy) fail_now("rand_drain");
    tick();
    tick();
    check("rand_rsp_left", lines_t'(rsp_q.size()), '0);
    check("rand_iss_left", lines_t'(iss_q.size()), '0);

    // Init flag dropped while running: still issues.
    notify_reg = 3'b000;
    drive(1'b1, 1'b0, 9, 'h55, '0, '0);
    tick();
    drive(1'b0, 1'b0, 0, 0, '0, '0);
    check("sticky_rd_en", lines_t'(cpl_loc_rd_en_q), lines_t'(1));
    check("sticky_idx", lines_t'(cpl_loc_index_q), lines_t'(9'h055));
    for (int j = 1; j <= 3; j++) begin
      tick();
      check($sformatf("sticky%0d_rsp_v", j), lines_t'(rif.rsp_valid), lines_t'(j == 3));
      if (j == 3) check("sticky_rsp_id", lines_t'(rif.rsp_id), lines_t'(9));
    end
    tick();
    tick();
    check("end_rsp_left", lines_t'(rsp_q.size()), '0);
    check("end_busy", lines_t'(busy), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
